// File: rtl/adc_capture.sv
// adc_capture
//   Capture stage behind the ADC sampler. Packed two-sample words (older in
//   [23:12], newer in [11:0]) arrive on adc_ready strobes, are buffered in a
//   small show-ahead FIFO and streamed to the memory writer over a
//   valid/ready handshake with sequential word addresses. After arm, words
//   are queued until the trigger word plus post_trigger_words more have been
//   enqueued; the FIFO then drains and the block parks in DONE.
//
//   Optional feature macro: ADC_CAPTURE_TRIGGER_EN
//     defined   : ARMED state waits for a rising crossing of trigger_level.
//     undefined : arm goes straight to POST; word 0 acts as the trigger word,
//                 so post_trigger_words+1 words are captured.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   arm                 one-cycle capture start (honoured in IDLE/DONE)
//   adc_ready           one-cycle strobe qualifying adc_data_double
//   adc_data_double     packed sample pair
//   trigger_level       threshold, latched at arm
//   post_trigger_words  words queued after the trigger word, latched at arm
//   mem_wr_valid/ready  memory handshake; mem_addr/mem_wdata give the head
//   busy                high outside IDLE and DONE
//   capture_done        high in DONE
//   trigger_addr        index of the word that held the trigger
//   overflow            sticky: a word was dropped on a full FIFO
module adc_capture #(
    parameter int ADDR_WIDTH = 21,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  adc_ready,
    input  logic [23:0]           adc_data_double,
    input  logic [11:0]           trigger_level,
    input  logic [ADDR_WIDTH-1:0] post_trigger_words,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [23:0]           mem_wdata,
    output logic                  busy,
    output logic                  capture_done,
    output logic [ADDR_WIDTH-1:0] trigger_addr,
    output logic                  overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0]           FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]           ONE_C    = (PW+1)'(1);
    localparam logic [PW-1:0]         ONE_P    = PW'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
`ifdef ADC_CAPTURE_TRIGGER_EN
        S_ARMED = 3'd1,
`endif
        S_POST  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [23:0]           fifo_q [FIFO_DEPTH];
    logic [23:0]           fifo_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;        // index of the next enqueued word
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;      // index of the FIFO head
    logic [ADDR_WIDTH-1:0] remain_q, remain_d;  // words still to enqueue after the current one
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic                  ovf_q, ovf_d;
    logic                  deq, enq, room, capturing;

`ifdef ADC_CAPTURE_TRIGGER_EN
    logic [11:0]           level_q, level_d;
    logic [11:0]           prev_lo_q, prev_lo_d;
    logic                  have_prev_q, have_prev_d;
    logic                  hit;
`else
    logic                  unused_level;
    assign unused_level = ^trigger_level;
`endif

    assign mem_wr_valid = (state_q != S_IDLE) && (cnt_q != '0);
    assign mem_wdata    = fifo_q[rd_ptr_q];
    assign mem_addr     = addr_q;
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign capture_done = (state_q == S_DONE);
    assign trigger_addr = trig_addr_q;
    assign overflow     = ovf_q;

    always_comb begin
        state_d     = state_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        trig_addr_d = trig_addr_q;
        ovf_d       = ovf_q;
`ifdef ADC_CAPTURE_TRIGGER_EN
        level_d     = level_q;
        prev_lo_d   = prev_lo_q;
        have_prev_d = have_prev_q;
        capturing   = (state_q == S_ARMED) || (state_q == S_POST);
        // Rising crossing inside the word, or from the previous word's newer
        // sample into this word's older sample.
        hit = ((adc_data_double[23:12] < level_q) && (adc_data_double[11:0] >= level_q))
           || (have_prev_q && (prev_lo_q < level_q) && (adc_data_double[23:12] >= level_q));
`else
        capturing   = (state_q == S_POST);
`endif
        deq  = mem_wr_valid && mem_wr_ready;
        // A full FIFO still accepts a word when the head leaves this cycle.
        room = (cnt_q != FULL_CNT) || deq;
        enq  = capturing && adc_ready && room;

        if (capturing && adc_ready && !room) ovf_d = 1'b1;

        if (enq) begin
            fifo_d[wr_ptr_q] = adc_data_double;
            wr_ptr_d         = wr_ptr_q + ONE_P;
            idx_d            = idx_q + ONE_A;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
            addr_d   = addr_q + ONE_A;
        end
        if (enq && !deq)      cnt_d = cnt_q + ONE_C;
        else if (!enq && deq) cnt_d = cnt_q - ONE_C;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    ovf_d       = 1'b0;
                    trig_addr_d = '0;
                    idx_d       = '0;
                    addr_d      = '0;
                    remain_d    = post_trigger_words;
`ifdef ADC_CAPTURE_TRIGGER_EN
                    level_d     = trigger_level;
                    have_prev_d = 1'b0;
                    state_d     = S_ARMED;
`else
                    state_d     = S_POST;
`endif
                end
            end
`ifdef ADC_CAPTURE_TRIGGER_EN
            S_ARMED: begin
                if (enq) begin
                    prev_lo_d   = adc_data_double[11:0];
                    have_prev_d = 1'b1;
                    if (hit) begin
                        trig_addr_d = idx_q;
                        if (remain_q == '0) begin
                            state_d = S_DRAIN;
                        end else begin
                            remain_d = remain_q - ONE_A;
                            state_d  = S_POST;
                        end
                    end
                end
            end
`endif
            S_POST: begin
                if (enq) begin
                    if (remain_q == '0) state_d = S_DRAIN;
                    else                remain_d = remain_q - ONE_A;
                end
            end
            S_DRAIN: begin
                // Leave on the edge that takes the last word so capture_done
                // follows the final transfer by one cycle.
                if ((cnt_q == '0) || ((cnt_q == ONE_C) && deq)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            remain_q    <= '0;
            trig_addr_q <= '0;
            ovf_q       <= 1'b0;
`ifdef ADC_CAPTURE_TRIGGER_EN
            level_q     <= '0;
            prev_lo_q   <= '0;
            have_prev_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            trig_addr_q <= trig_addr_d;
            ovf_q       <= ovf_d;
`ifdef ADC_CAPTURE_TRIGGER_EN
            level_q     <= level_d;
            prev_lo_q   <= prev_lo_d;
            have_prev_q <= have_prev_d;
`endif
        end
    end
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture
//   Directed bench for adc_capture (ADDR_WIDTH=4, FIFO_DEPTH=8). A queue
//   based model tracks phase, FIFO contents and flags from the stimulus; a
//   compare process checks every DUT output against it each cycle, and a
//   log of accepted transfers is checked against hand-computed literals.
`timescale 1ns/1ps
module tb_adc_capture;
    localparam int AW    = 4;
    localparam int DEPTH = 8;
    localparam int MASK  = (1 << AW) - 1;
`ifdef ADC_CAPTURE_TRIGGER_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          arm;
    logic          adc_ready;
    logic [23:0]   adc_data_double;
    logic [11:0]   trigger_level;
    logic [AW-1:0] post_trigger_words;
    logic          mem_wr_valid;
    logic          mem_wr_ready;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic          busy;
    logic          capture_done;
    logic [AW-1:0] trigger_addr;
    logic          overflow;

    adc_capture #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .arm               (arm),
        .adc_ready         (adc_ready),
        .adc_data_double   (adc_data_double),
        .trigger_level     (trigger_level),
        .post_trigger_words(post_trigger_words),
        .mem_wr_valid      (mem_wr_valid),
        .mem_wr_ready      (mem_wr_ready),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .busy              (busy),
        .capture_done      (capture_done),
        .trigger_addr      (trigger_addr),
        .overflow          (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, want, $time);
        end
    endtask

    // ---------------- model ----------------
    // phase: 0 idle, 1 armed, 2 post, 3 drain, 4 done
    int          m_ph = 0, m_idx = 0, m_trig = 0, m_left = 0, m_lvl = 0, m_prev = -1;
    bit          m_ovf = 1'b0;
    logic [23:0] mq_data[$];
    int          mq_idx[$];

    task automatic model_step();
        int d, hi, lo, sz;
        bit dq, hit;
        if (reset) begin
            m_ph = 0; m_idx = 0; m_trig = 0; m_left = 0; m_prev = -1; m_ovf = 1'b0;
            mq_data.delete(); mq_idx.delete();
            return;
        end
        sz = mq_data.size();
        dq = (m_ph != 0) && (sz > 0) && mem_wr_ready;
        if (dq) begin mq_data.delete(0); mq_idx.delete(0); end
        d  = int'(adc_data_double);
        hi = d >> 12;
        lo = d & 'hFFF;
        case (m_ph)
            0, 4: if (arm) begin
                m_ovf = 1'b0; m_trig = 0; m_idx = 0; m_prev = -1;
                m_left = int'(post_trigger_words);
                m_lvl  = int'(trigger_level);
                m_ph   = TRIG_EN ? 1 : 2;
            end
            1, 2: if (adc_ready) begin
                if (sz == DEPTH && !dq) m_ovf = 1'b1;
                else begin
                    mq_data.push_back(adc_data_double);
                    mq_idx.push_back(m_idx);
                    if (m_ph == 1) begin
                        hit = (hi < m_lvl && lo >= m_lvl) ||
                              (m_prev >= 0 && m_prev < m_lvl && hi >= m_lvl);
                        m_prev = lo;
                        if (hit) begin
                            m_trig = m_idx;
                            if (m_left == 0) m_ph = 3;
                            else begin m_left--; m_ph = 2; end
                        end
                    end else begin
                        if (m_left == 0) m_ph = 3;
                        else m_left--;
                    end
                    m_idx++;
                end
            end
            3: if (mq_data.size() == 0) m_ph = 4;
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    task automatic compare();
        bit ev;
        ev = (m_ph != 0) && (mq_data.size() > 0);
        chk("busy",      32'(busy),         32'(m_ph >= 1 && m_ph <= 3));
        chk("done",      32'(capture_done), 32'(m_ph == 4));
        chk("overflow",  32'(overflow),     32'(m_ovf));
        chk("trig_addr", 32'(trigger_addr), 32'(m_trig & MASK));
        chk("valid",     32'(mem_wr_valid), 32'(ev));
        if (ev && mem_wr_valid) begin
            chk("wdata", 32'(mem_wdata), 32'(mq_data[0]));
            chk("addr",  32'(mem_addr),  32'(mq_idx[0] & MASK));
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_on) compare();
    end

    // ---------------- transfer log ----------------
    int          lg_addr[$];
    logic [23:0] lg_data[$];

    initial forever begin
        @(negedge clk);
        if (chk_on && !reset && mem_wr_valid && mem_wr_ready) begin
            lg_addr.push_back(int'(mem_addr));
            lg_data.push_back(mem_wdata);
        end
    end

    function automatic int lga(input int i);
        return (i < lg_addr.size()) ? lg_addr[i] : 32'hDEAD;
    endfunction
    function automatic logic [31:0] lgd(input int i);
        return (i < lg_data.size()) ? 32'(lg_data[i]) : 32'hDEADBEEF;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [23:0] w);
        adc_data_double = w;
        adc_ready = 1'b1;
        tick();
        adc_ready = 1'b0;
        tick();
    endtask

    task automatic start(input int post, input logic [11:0] lvl);
        lg_addr.delete(); lg_data.delete();
        post_trigger_words = AW'(post);
        trigger_level = lvl;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!capture_done && n < 200) begin tick(); n++; end
        chk(nm, 32'(capture_done), 32'd1);
    endtask

    function automatic logic [23:0] wk(input int k);
        return (k == 0) ? 24'h000FFF : 24'(k * 32'h010203);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int errs;
        reset = 1'b1; arm = 1'b0; adc_ready = 1'b0; adc_data_double = '0;
        trigger_level = '0; post_trigger_words = '0; mem_wr_ready = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_valid", 32'(mem_wr_valid), 32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_done",  32'(capture_done), 32'd0);
        chk("rst_ovf",   32'(overflow),     32'd0);
        chk("rst_addr",  32'(mem_addr),     32'd0);
        chk("rst_trig",  32'(trigger_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata),    32'd0);
        reset = 1'b0;
        mem_wr_ready = 1'b1;
        tick();

        // post=0: exactly one write, to address 0
        start(0, 12'hFFF);
        feed(24'h000FFF);
        feed(24'h0A0B0C);
        wait_done("t1_done");
        chk("t1_nwr",  32'(lg_addr.size()), 32'd1);
        chk("t1_addr", 32'(lga(0)), 32'd0);
        chk("t1_data", lgd(0), 32'h000FFF);

        // post=3: four words, the rest ignored
        start(3, 12'hFFF);
        feed(24'h000FFF); feed(24'h123456); feed(24'h789ABC);
        feed(24'hDEF012); feed(24'h345678); feed(24'h9ABCDE);
        wait_done("t2_done");
        chk("t2_nwr",   32'(lg_addr.size()), 32'd4);
        chk("t2_addr3", 32'(lga(3)), 32'd3);
        chk("t2_data3", lgd(3), 32'hDEF012);
        chk("t2_trig",  32'(trigger_addr), 32'd0);

        // backpressure: 10 words offered over 20 cycles into an 8-deep FIFO
        mem_wr_ready = 1'b0;
        start(15, 12'hFFF);
        for (int k = 0; k < 10; k++) feed(wk(k));
        chk("t3_ovf",   32'(overflow),     32'd1);
        chk("t3_valid", 32'(mem_wr_valid), 32'd1);
        chk("t3_head",  32'(mem_addr),     32'd0);
        mem_wr_ready = 1'b1;
        for (int k = 10; k < 18; k++) feed(wk(k));
        wait_done("t3_done");
        chk("t3_nwr", 32'(lg_addr.size()), 32'd16);
        errs = 0;
        for (int i = 0; i < 16; i++) if (lga(i) != i) errs++;
        chk("t3_contig", 32'(errs), 32'd0);
        chk("t3_data7", lgd(7), 32'h070E15);
        chk("t3_data8", lgd(8), 32'h0A141E);

        // full FIFO with simultaneous enqueue and dequeue: stored, no overflow
        mem_wr_ready = 1'b0;
        start(8, 12'hFFF);
        for (int k = 0; k < 8; k++) feed(wk(k));
        adc_data_double = 24'hC0FFEE;
        adc_ready = 1'b1;
        mem_wr_ready = 1'b1;
        tick();
        adc_ready = 1'b0;
        tick();
        wait_done("t4_done");
        chk("t4_ovf",   32'(overflow), 32'd0);
        chk("t4_nwr",   32'(lg_addr.size()), 32'd9);
        chk("t4_data8", lgd(8), 32'hC0FFEE);

        // reset with words queued abandons the capture
        mem_wr_ready = 1'b0;
        start(10, 12'hFFF);
        feed(24'h000FFF); feed(24'h111111); feed(24'h222222);
        reset = 1'b1;
        tick();
        chk("t5_valid", 32'(mem_wr_valid), 32'd0);
        chk("t5_busy",  32'(busy),         32'd0);
        reset = 1'b0;
        mem_wr_ready = 1'b1;
        tick();
        start(1, 12'hFFF);
        feed(24'h000FFF);
        feed(24'h5A5A5A);
        wait_done("t5_done");
        chk("t5_nwr",   32'(lg_addr.size()), 32'd2);
        chk("t5_addr0", 32'(lga(0)), 32'd0);
        chk("t5_addr1", 32'(lga(1)), 32'd1);
        chk("t5_data1", lgd(1), 32'h5A5A5A);

`ifdef ADC_CAPTURE_TRIGGER_EN
        // trigger inside the second word
        start(3, 12'h800);
        feed(24'h100200); feed(24'h300900); feed(24'h111111);
        feed(24'h222222); feed(24'h333333); feed(24'h444444);
        wait_done("tm_done");
        chk("tm_trig",  32'(trigger_addr), 32'd1);
        chk("tm_nwr",   32'(lg_addr.size()), 32'd5);
        chk("tm_addr4", 32'(lga(4)), 32'd4);
        chk("tm_data4", lgd(4), 32'h333333);

        // first word has no predecessor; later crossing spans two words
        start(1, 12'h800);
        feed(24'h900100); feed(24'h7000F0); feed(24'h900100);
        feed(24'h555555); feed(24'h666666);
        wait_done("tc_done");
        chk("tc_trig",  32'(trigger_addr), 32'd2);
        chk("tc_nwr",   32'(lg_addr.size()), 32'd4);
        chk("tc_data3", lgd(3), 32'h555555);

        // address wrap with a 4-bit address
        start(2, 12'h800);
        for (int i = 0; i < 20; i++) feed({12'(12'h100 + i), 12'(12'h200 + i)});
        feed(24'h100900); feed(24'hABCABC); feed(24'h123123);
        wait_done("tw_done");
        chk("tw_trig",   32'(trigger_addr), 32'd4);
        chk("tw_nwr",    32'(lg_addr.size()), 32'd23);
        chk("tw_addr15", 32'(lga(15)), 32'd15);
        chk("tw_addr16", 32'(lga(16)), 32'd0);
        chk("tw_addr22", 32'(lga(22)), 32'd6);
        chk("tw_data22", lgd(22), 32'h123123);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
